// File: rtl/event_pkg.sv
// Shared event encoding for the game event queue: codes, pulse-vector
// bit positions and the fixed service priority.
package event_pkg;

  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_BAD    = 3'd1,
    EV_GOOD   = 3'd2,
    EV_BUTTON = 3'd3,
    EV_DIR0   = 3'd4,
    EV_DIR1   = 3'd5,
    EV_DIR2   = 3'd6,
    EV_DIR3   = 3'd7
  } event_t;

  localparam int NUM_EVENTS = 7;

  localparam int IDX_BAD    = 0;
  localparam int IDX_GOOD   = 1;
  localparam int IDX_BUTTON = 2;
  localparam int IDX_DIR0   = 3;

  // Slot i of this vector is the code granted for pulse-vector bit i;
  // bit 0 has the highest priority.
  localparam logic [3*NUM_EVENTS-1:0] PRIO_ORDER = {
    EV_DIR3, EV_DIR2, EV_DIR1, EV_DIR0, EV_BUTTON, EV_GOOD, EV_BAD
  };

  function automatic logic [NUM_EVENTS-1:0] lowest_set(input logic [NUM_EVENTS-1:0] req);
    return req & (~req + 7'd1);
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous DEPTH-entry FIFO of event codes; head reads NONE when empty,
// pops on empty and pushes on full-without-pop are ignored.
module event_fifo
  import event_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     push,
  input  event_t                   push_data,
  input  logic                     pop,
  output event_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  event_t          mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            do_push_s;
  logic            do_pop_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign count     = count_r;

  // head of queue, forced to NONE while empty
  always_comb begin
    head = EV_NONE;
    if (empty) begin
      head = EV_NONE;
    end else begin
      head = mem_r[rd_ptr_r];
    end
  end

  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= EV_NONE;
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/event_queue.sv
// Serialises one-cycle game event pulses into a priority-ordered FIFO of
// event codes, tracks lost (coalesced) events and the latest direction.
module event_queue
  import event_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     goodColl,
  input  logic                     badColl,
  input  logic                     button,
  input  logic [3:0]               direction,
  input  logic                     event_ready,
  input  logic                     clear_ovf,
  output logic                     event_valid,
  output logic [2:0]               event_code,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [3:0]               last_dir
);

  logic [NUM_EVENTS-1:0] pulses_s;
  logic [NUM_EVENTS-1:0] pending_r;
  logic [NUM_EVENTS-1:0] grant_s;
  logic [NUM_EVENTS-1:0] coalesce_s;
  logic [2:0]            code_bits_s;
  event_t                grant_code_s;
  event_t                head_s;
  logic                  push_ok_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  overflow_r;
  logic [3:0]            last_dir_r;

  // gather the individual pulse inputs into one vector
  always_comb begin
    pulses_s                 = '0;
    pulses_s[IDX_BAD]        = badColl;
    pulses_s[IDX_GOOD]       = goodColl;
    pulses_s[IDX_BUTTON]     = button;
    pulses_s[IDX_DIR0 +: 4]  = direction;
  end

  assign pop_s     = !empty_s && event_ready;
  assign push_ok_s = !full_s || pop_s;

  // grant the highest-priority registered pending event when the FIFO can take it
  always_comb begin
    grant_s     = '0;
    code_bits_s = 3'd0;
    if (push_ok_s) begin
      grant_s = lowest_set(pending_r);
    end else begin
      grant_s = '0;
    end
    for (int i = 0; i < NUM_EVENTS; i++) begin
      code_bits_s = code_bits_s | (PRIO_ORDER[3*i +: 3] & {3{grant_s[i]}});
    end
  end

  assign grant_code_s = event_t'(code_bits_s);
  assign push_s       = |grant_s;
  // a pulse that lands on a still-waiting event merges into it and is lost
  assign coalesce_s   = pulses_s & pending_r & ~grant_s;

  event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nRst      (nRst),
    .push      (push_s),
    .push_data (grant_code_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count)
  );

  assign event_valid = !empty_s;
  assign event_code  = head_s;
  assign overflow    = overflow_r;
  assign last_dir    = last_dir_r;

  // pending events, sticky overflow and latest direction
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pending_r  <= '0;
      overflow_r <= 1'b0;
      last_dir_r <= 4'b0000;
    end else begin
      pending_r <= (pending_r & ~grant_s) | pulses_s;
      if (|coalesce_s) begin
        overflow_r <= 1'b1;
      end else if (clear_ovf) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (|direction) begin
        last_dir_r <= direction & (~direction + 4'd1);
      end else begin
        last_dir_r <= last_dir_r;
      end
    end
  end

endmodule

// File: tb/tb_event_queue.sv
// Randomised and directed bench for event_queue against a queue-based
// reference model of pending events, FIFO contents, overflow and last_dir.
module tb_event_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       goodColl = 1'b0;
  logic       badColl = 1'b0;
  logic       button = 1'b0;
  logic [3:0] direction = 4'b0000;
  logic       event_ready = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       event_valid;
  logic [2:0] event_code;
  logic [$clog2(DEPTH):0] count;
  logic       overflow;
  logic [3:0] last_dir;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: pending flag per event code 1..7, FIFO as a queue
  bit [7:0] m_pend;
  int       m_q[$];
  bit       m_ovf;
  bit [3:0] m_last;

  int       dut_pops;
  int       pop_log[$];

  event_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .nRst        (nRst),
    .goodColl    (goodColl),
    .badColl     (badColl),
    .button      (button),
    .direction   (direction),
    .event_ready (event_ready),
    .clear_ovf   (clear_ovf),
    .event_valid (event_valid),
    .event_code  (event_code),
    .count       (count),
    .overflow    (overflow),
    .last_dir    (last_dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_q.delete();
    m_ovf  = 1'b0;
    m_last = 4'b0000;
  endtask

  // one clock edge of the specified behaviour
  task automatic model_step(input bit gc, input bit bc, input bit bt,
                            input bit [3:0] dir, input bit rdy, input bit clr);
    bit [7:0] pulse;
    bit       pop, room, coal;
    int       g;
    pulse = '0;
    pulse[1] = bc;
    pulse[2] = gc;
    pulse[3] = bt;
    for (int i = 0; i < 4; i++) pulse[4+i] = dir[i];
    pop  = (m_q.size() > 0) && rdy;
    room = (m_q.size() < DEPTH) || pop;
    g = 0;
    if (room)
      for (int c = 1; c <= 7; c++)
        if (m_pend[c] && g == 0) g = c;
    coal = 1'b0;
    for (int c = 1; c <= 7; c++)
      if (pulse[c] && m_pend[c] && c != g) coal = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (g != 0) begin
      m_q.push_back(g);
      m_pend[g] = 1'b0;
    end
    m_pend = m_pend | pulse;
    if (coal) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (dir != 4'b0000) begin
      for (int i = 3; i >= 0; i--)
        if (dir[i]) m_last = 4'b0001 << i;
    end
  endtask

  task automatic cycle(input bit gc, input bit bc, input bit bt,
                       input bit [3:0] dir, input bit rdy, input bit clr);
    model_step(gc, bc, bt, dir, rdy, clr);
    goodColl    = gc;
    badColl     = bc;
    button      = bt;
    direction   = dir;
    event_ready = rdy;
    clear_ovf   = clr;
    if (event_valid && rdy) begin
      dut_pops++;
      pop_log.push_back(int'(event_code));
    end
    @(posedge clk);
    #1;
    check("event_valid", event_valid, m_q.size() != 0);
    check("event_code", event_code, (m_q.size() != 0) ? m_q[0] : 0);
    check("count", count, m_q.size());
    check("overflow", overflow, m_ovf);
    check("last_dir", last_dir, m_last);
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 1'b0, 1'b0, 4'b0000, rdy, 1'b0);
  endtask

  initial begin
    int exp_codes[4];
    exp_codes = '{2, 4, 5, 7};
    model_reset();
    dut_pops = 0;
    #12;
    check("rst_valid", event_valid, 0);
    check("rst_code", event_code, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_last_dir", last_dir, 0);
    @(negedge clk);
    nRst = 1'b1;

    // two-edge latency, then pop
    cycle(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    check("lat_e0_valid", event_valid, 0);
    idle(1'b1);
    check("lat_e1_valid", event_valid, 1);
    check("lat_e1_code", event_code, 1);
    idle(1'b1);
    check("lat_drained", count, 0);

    // simultaneous good + directions, consumer stalled
    cycle(1'b1, 1'b0, 1'b0, 4'b1011, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b0);
    check("multi_count", count, 4);
    check("multi_ovf", overflow, 0);
    check("multi_last_dir", last_dir, 4'b0001);
    pop_log.delete();
    for (int i = 0; i < 4; i++) idle(1'b1);
    for (int i = 0; i < 4; i++)
      check("multi_order", (pop_log.size() > i) ? pop_log[i] : 0, exp_codes[i]);

    // six distinct pulses with consumer stalled, then drain
    dut_pops = 0;
    cycle(1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("sat_count", count, 4);
    for (int i = 0; i < 10; i++) idle(1'b1);
    check("sat_delivered", dut_pops, 6);
    check("sat_ovf", overflow, 0);

    // overflow set / clear / set-wins
    cycle(1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b0);
    cycle(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    check("ovf_set", overflow, 1);
    cycle(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    check("ovf_clear", overflow, 0);
    cycle(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
    check("ovf_set_wins", overflow, 1);

    // full FIFO with pop and pending: push and pop together
    idle(1'b1);
    check("full_pushpop_count", count, 4);
    for (int i = 0; i < 8 && m_q.size() != 3; i++) idle(1'b1);
    check("pre_reset_count", count, 3);

    // asynchronous reset mid-drain
    #2;
    nRst = 1'b0;
    #1;
    check("arst_valid", event_valid, 0);
    check("arst_code", event_code, 0);
    check("arst_count", count, 0);
    check("arst_ovf", overflow, 0);
    check("arst_last_dir", last_dir, 0);
    model_reset();
    goodColl = 1'b0; badColl = 1'b0; button = 1'b0; direction = 4'b0000;
    event_ready = 1'b0; clear_ovf = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    check("post_rst_e0", event_valid, 0);
    idle(1'b0);
    check("post_rst_e1", event_code, 2);

    // randomised traffic with varying consumer duty
    for (int seg = 0; seg < 6; seg++) begin
      int rdy_pct;
      rdy_pct = (seg % 3 == 0) ? 20 : ((seg % 3 == 1) ? 60 : 95);
      for (int n = 0; n < 80; n++) begin
        bit [3:0] d;
        for (int b = 0; b < 4; b++) d[b] = ($urandom_range(0, 5) == 0);
        cycle($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 4) == 0, d,
              $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 15) == 0);
      end
    end
    for (int i = 0; i < 12; i++) idle(1'b1);
    check("final_empty", count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
